// File: rtl/sum_accum_sequencer.sv
// -----------------------------------------------------------------------------
// sum_accum_sequencer
//   Job controller for one sum_accumulator instance. A job (op, two operands,
//   repeat count) is accepted on the request handshake. The controller pulses
//   the accumulator reset for one cycle, then drives the operands and select
//   for 'count' cycles. It waits one cycle for the last registered add to
//   appear and returns the wrapped sum plus a sticky overflow on the response
//   handshake. Every output is a flop, including the accumulator reset.
//
// Ports
//   i_clk, i_rst_n            clock, async active-low reset
//   i_req_valid/o_req_ready   job request handshake
//   i_req_op                  0=DATA1, 1=DATA2, 2=SUM, 3=reserved
//   i_req_data1/2, i_req_count  job operands and number of accumulation cycles
//   o_rsp_valid/i_rsp_ready   result handshake
//   o_rsp_data                accumulated result (mod 2^NB_DATA_OUT)
//   o_rsp_overflow            any add carried out during the job
//   o_rsp_err                 job used the reserved op
//   o_busy                    high in every state except IDLE
//   o_acc_rst_n, o_acc_data1/2, o_acc_sel   drive the accumulator
//   i_acc_data, i_acc_overflow              accumulator outputs
// -----------------------------------------------------------------------------
module sum_accum_sequencer #(
    parameter int NB_DATA_IN  = 3,
    parameter int NB_SEL      = 2,
    parameter int NB_DATA_OUT = 6,
    parameter int NB_COUNT    = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [1:0]             i_req_op,
    input  logic [NB_DATA_IN-1:0]  i_req_data1,
    input  logic [NB_DATA_IN-1:0]  i_req_data2,
    input  logic [NB_COUNT-1:0]    i_req_count,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [NB_DATA_OUT-1:0] o_rsp_data,
    output logic                   o_rsp_overflow,
    output logic                   o_rsp_err,
    output logic                   o_busy,
    output logic                   o_acc_rst_n,
    output logic [NB_DATA_IN-1:0]  o_acc_data1,
    output logic [NB_DATA_IN-1:0]  o_acc_data2,
    output logic [NB_SEL-1:0]      o_acc_sel,
    input  logic [NB_DATA_OUT-1:0] i_acc_data,
    input  logic                   i_acc_overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_RSVD = 2'd3;

    // Accumulator select encoding; 2'b11 is never driven.
    localparam logic [NB_SEL-1:0] SEL_DATA1 = NB_SEL'(2'b10);
    localparam logic [NB_SEL-1:0] SEL_DATA2 = NB_SEL'(2'b00);
    localparam logic [NB_SEL-1:0] SEL_SUM   = NB_SEL'(2'b01);

    state_t                 state;
    logic [1:0]             op_q;
    logic [NB_DATA_IN-1:0]  data1_q;
    logic [NB_DATA_IN-1:0]  data2_q;
    logic [NB_COUNT-1:0]    cnt;
    logic                   sticky_ovf;
    logic                   rsvd;

    assign rsvd = (op_q == OP_RSVD);

    function automatic logic [NB_SEL-1:0] sel_for(input logic [1:0] op);
        case (op)
            2'd0:    return SEL_DATA1;
            2'd2:    return SEL_SUM;
            default: return SEL_DATA2;   // DATA2, and reserved with zero operands
        endcase
    endfunction

    // NOTE: all state is assigned with non-blocking (<=) so every flop samples
    // the pre-edge values of the others; blocking here would chain updates
    // within one edge and break the registered-output timing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the latched job fields are reset too, so an aborted job
            // leaves nothing behind for the next one.
            state          <= S_IDLE;
            op_q           <= '0;
            data1_q        <= '0;
            data2_q        <= '0;
            cnt            <= '0;
            sticky_ovf     <= 1'b0;
            o_req_ready    <= 1'b0;
            o_rsp_valid    <= 1'b0;
            o_rsp_data     <= '0;
            o_rsp_overflow <= 1'b0;
            o_rsp_err      <= 1'b0;
            o_busy         <= 1'b0;
            o_acc_rst_n    <= 1'b0;
            o_acc_data1    <= '0;
            o_acc_data2    <= '0;
            o_acc_sel      <= SEL_DATA2;
        end else begin
            case (state)
                S_IDLE: begin
                    o_acc_rst_n <= 1'b1;
                    o_req_ready <= 1'b1;
                    if (i_req_valid && o_req_ready) begin
                        op_q        <= i_req_op;
                        data1_q     <= i_req_data1;
                        data2_q     <= i_req_data2;
                        cnt         <= i_req_count;
                        o_req_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        // Low for exactly the CLEAR cycle.
                        o_acc_rst_n <= 1'b0;
                        state       <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    o_acc_rst_n <= 1'b1;
                    sticky_ovf  <= 1'b0;
                    if (cnt != '0) begin
                        o_acc_data1 <= rsvd ? '0 : data1_q;
                        o_acc_data2 <= rsvd ? '0 : data2_q;
                        o_acc_sel   <= sel_for(op_q);
                        state       <= S_RUN;
                    end else begin
                        state <= S_DRAIN;
                    end
                end

                S_RUN: begin
                    cnt        <= cnt - NB_COUNT'(1);
                    sticky_ovf <= sticky_ovf | i_acc_overflow;
                    if (cnt == NB_COUNT'(1)) begin
                        // Back to adding zero so the result holds from here on.
                        o_acc_data1 <= '0;
                        o_acc_data2 <= '0;
                        o_acc_sel   <= SEL_DATA2;
                        state       <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    // The last add of RUN is visible on the accumulator only now.
                    o_rsp_data     <= rsvd ? '0 : i_acc_data;
                    o_rsp_overflow <= rsvd ? 1'b0 : (sticky_ovf | i_acc_overflow);
                    o_rsp_err      <= rsvd;
                    o_rsp_valid    <= 1'b1;
                    state          <= S_DONE;
                end

                S_DONE: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        o_req_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accum_sequencer.sv
module tb_sum_accum_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_data1;
    logic [2:0] req_data2;
    logic [3:0] req_count;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_data;
    logic       rsp_overflow;
    logic       rsp_err;
    logic       busy;
    logic       acc_rst_n;
    logic [2:0] acc_data1;
    logic [2:0] acc_data2;
    logic [1:0] acc_sel;
    logic [5:0] acc_data;
    logic       acc_overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sum_accum_sequencer #(
        .NB_DATA_IN (3),
        .NB_SEL     (2),
        .NB_DATA_OUT(6),
        .NB_COUNT   (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_op      (req_op),
        .i_req_data1   (req_data1),
        .i_req_data2   (req_data2),
        .i_req_count   (req_count),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_data    (rsp_data),
        .o_rsp_overflow(rsp_overflow),
        .o_rsp_err     (rsp_err),
        .o_busy        (busy),
        .o_acc_rst_n   (acc_rst_n),
        .o_acc_data1   (acc_data1),
        .o_acc_data2   (acc_data2),
        .o_acc_sel     (acc_sel),
        .i_acc_data    (acc_data),
        .i_acc_overflow(acc_overflow)
    );

    // Behavioural sum_accumulator: adds the selected value every clock,
    // registered result and registered per-add carry.
    logic [3:0] addend;
    logic       sel11_seen = 1'b0;

    always_comb begin
        addend = '0;
        case (acc_sel)
            2'b10:   addend = {1'b0, acc_data1};
            2'b00:   addend = {1'b0, acc_data2};
            2'b01:   addend = {1'b0, acc_data1} + {1'b0, acc_data2};
            default: addend = '0;
        endcase
    end

    always @(posedge clk or negedge acc_rst_n) begin
        if (!acc_rst_n) begin
            acc_data     <= '0;
            acc_overflow <= 1'b0;
        end else begin
            {acc_overflow, acc_data} <= {1'b0, acc_data} + {3'b000, addend};
        end
    end

    always @(negedge clk) begin
        if (acc_sel == 2'b11) sel11_seen = 1'b1;
    end

    typedef struct {
        logic [1:0] op;
        logic [2:0] d1;
        logic [2:0] d2;
        logic [3:0] cnt;
        logic [5:0] data;
        logic       ovf;
        logic       err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called just after a negedge in IDLE; returns just after the negedge of
    // the CLEAR cycle.
    task automatic start_job(input logic [1:0] op, input logic [2:0] d1,
                             input logic [2:0] d2, input logic [3:0] cnt);
        req_op    = op;
        req_data1 = d1;
        req_data2 = d2;
        req_count = cnt;
        req_valid = 1'b1;
        check("req_ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("req_ready_after_accept", req_ready, 0);
    endtask

    // Latency = cycles from the request cycle up to (not including) the first
    // cycle with rsp_valid high. Also counts cycles with acc_rst_n low.
    task automatic wait_rsp(output int lat, output int lows);
        int n;
        n    = 2;
        lows = 0;
        while (!rsp_valid && n < 64) begin
            if (!acc_rst_n) lows++;
            @(negedge clk);
            n++;
        end
        check("rsp_timeout", rsp_valid, 1);
        lat = n - 1;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_after_consume", rsp_valid, 0);
        check("req_ready_after_consume", req_ready, 1);
        check("busy_after_consume", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_ovf"}, rsp_overflow, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_acc_rst_n"}, acc_rst_n, 0);
        check({tag, "_acc_data1"}, acc_data1, 0);
        check({tag, "_acc_data2"}, acc_data2, 0);
        check({tag, "_acc_sel"}, acc_sel, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        int  lows;
        logic seen;

        // op, d1, d2, count, expected data, ovf, err
        vecs[0] = '{2'd0, 3'd5, 3'd6, 4'd3,  6'd15, 1'b0, 1'b0};  // 5*3
        vecs[1] = '{2'd2, 3'd7, 3'd7, 4'd5,  6'd6,  1'b1, 1'b0};  // 70 mod 64
        vecs[2] = '{2'd1, 3'd6, 3'd7, 4'd9,  6'd63, 1'b0, 1'b0};  // 7*9, no carry
        vecs[3] = '{2'd1, 3'd6, 3'd7, 4'd10, 6'd6,  1'b1, 1'b0};  // 70 mod 64
        vecs[4] = '{2'd0, 3'd5, 3'd3, 4'd0,  6'd0,  1'b0, 1'b0};  // no adds
        vecs[5] = '{2'd2, 3'd3, 3'd4, 4'd1,  6'd7,  1'b0, 1'b0};  // single add

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_data1 = '0;
        req_data2 = '0;
        req_count = '0;
        rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);
        check("acc_rst_n_release", acc_rst_n, 1);
        check("req_ready_release", req_ready, 1);

        for (int i = 0; i < 6; i++) begin
            start_job(vecs[i].op, vecs[i].d1, vecs[i].d2, vecs[i].cnt);
            wait_rsp(lat, lows);
            check($sformatf("v%0d_latency", i), lat, 32'(vecs[i].cnt) + 3);
            check($sformatf("v%0d_acc_rst_low", i), lows, 1);
            check($sformatf("v%0d_data", i), rsp_data, vecs[i].data);
            check($sformatf("v%0d_ovf", i), rsp_overflow, vecs[i].ovf);
            check($sformatf("v%0d_err", i), rsp_err, vecs[i].err);
            consume();
        end

        // Reserved op with the response held off for 5 cycles.
        start_job(2'd3, 3'd7, 3'd7, 4'd4);
        wait_rsp(lat, lows);
        check("rsvd_latency", lat, 7);
        for (int k = 0; k < 5; k++) begin
            check("rsvd_hold_valid", rsp_valid, 1);
            check("rsvd_hold_data", rsp_data, 0);
            check("rsvd_hold_ovf", rsp_overflow, 0);
            check("rsvd_hold_err", rsp_err, 1);
            check("rsvd_hold_req_ready", req_ready, 0);
            @(negedge clk);
        end
        consume();
        start_job(2'd0, 3'd1, 3'd0, 4'd2);
        wait_rsp(lat, lows);
        check("after_rsvd_data", rsp_data, 2);
        check("after_rsvd_err", rsp_err, 0);
        consume();

        // Reset pulsed while the job is in RUN.
        start_job(2'd0, 3'd5, 3'd0, 4'd8);
        repeat (3) @(negedge clk);
        check("midrun_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrun_acc_rst_n_release", acc_rst_n, 1);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            seen |= rsp_valid;
            @(negedge clk);
        end
        check("midrun_no_rsp", seen, 0);
        start_job(2'd0, 3'd3, 3'd0, 4'd2);
        wait_rsp(lat, lows);
        check("post_abort_data", rsp_data, 6);
        check("post_abort_ovf", rsp_overflow, 0);
        consume();

        check("sel_11_never_driven", sel11_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
